// File: rtl/copro_result_buffer.sv
// In-order result FIFO between the fixed-point execution unit and the core's result port.
// Issue credits keep a slot free for every in-flight instruction, since the unit cannot stall.
module copro_result_buffer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            issue_valid_i,
    output logic            issue_ready_o,

    input  logic            unit_valid_i,
    input  logic            unit_we_i,
    input  logic [XLEN-1:0] unit_result_i,
    input  hartid_t         unit_hartid_i,
    input  id_t             unit_id_i,
    input  logic [4:0]      unit_rd_i,

    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_data_o,
    output hartid_t         result_hartid_o,
    output id_t             result_id_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o,

    output logic            overflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic            overflow_q, overflow_d;

    logic            issue_fire;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic [CW:0]     credit_sum;

    // Credits count both buffered and in-flight results; registers only, no input paths.
    assign credit_sum    = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready_o = credit_sum < (CW+1)'(DEPTH);

    assign issue_fire = issue_valid_i & issue_ready_o;
    assign push       = unit_valid_i;
    assign pop        = result_valid_o & result_ready_i;
    assign full       = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en      = push & (~full | pop);

    assign wr_entry = '{we:     unit_we_i,
                        data:   unit_result_i,
                        hartid: unit_hartid_i,
                        id:     unit_id_i,
                        rd:     unit_rd_i};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        overflow_d = overflow_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);

        // A stray result with nothing in flight is still buffered; the counter saturates at 0.
        if (issue_fire && !push)
            inflight_d = inflight_q + CW'(1);
        else if (push && !issue_fire && inflight_q != '0)
            inflight_d = inflight_q - CW'(1);

        if (push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so the head fields read as zero while empty after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign result_valid_o  = (count_q != '0);
    assign result_data_o   = head.data;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign result_rd_o     = head.rd;
    assign result_we_o     = head.we;
    assign overflow_o      = overflow_q;

endmodule

// File: doc/copro_result_buffer.md
# copro_result_buffer

Result-side consumer for the fixed-point coprocessor execution unit: captures the unit's one-shot registered result, which has no backpressure, into an in-order FIFO and presents it to the core's CV-X-IF result interface with a valid/ready handshake. Issue credits gate new instructions into the unit so a result always has a FIFO slot when it arrives. Sits between the execution unit's result outputs and the core's result port, inside the coprocessor top.

## Interface
- XLEN, 32, result data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- hartid_t, logic, hart identifier type
- id_t, logic, instruction identifier type
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  core offers an instruction to the execution unit
- issue_ready_o  out  1  credit available; instruction may enter the unit
- unit_valid_i  in  1  execution unit result valid (one-cycle pulse per instruction)
- unit_we_i  in  1  result writes rd
- unit_result_i  in  XLEN  result data
- unit_hartid_i  in  hartid_t  result hart id
- unit_id_i  in  id_t  result instruction id
- unit_rd_i  in  5  destination register
- result_valid_o  out  1  head entry valid toward core
- result_ready_i  in  1  core accepts head entry
- result_data_o  out  XLEN  head data
- result_hartid_o  out  hartid_t  head hart id
- result_id_o  out  id_t  head id
- result_rd_o  out  5  head rd
- result_we_o  out  1  head write enable
- overflow_o  out  1  sticky error: result arrived with FIFO full and no pop

## Operation
- issue_fire = issue_valid_i & issue_ready_o; push = unit_valid_i; pop = result_valid_o & result_ready_i.
- count_q (0..DEPTH, $clog2(DEPTH)+1 bits): FIFO occupancy. inflight_q (same width): issued, result not yet received.
- issue_ready_o = (count_q + inflight_q) < DEPTH, combinational from registers only (no dependency on issue_valid_i or result_ready_i).
- inflight_q: +1 on issue_fire, -1 on push, unchanged when both; never underflows (push with inflight_q==0 still accepted into FIFO, inflight_q held at 0).
- FIFO: circular buffer, wr_ptr/rd_ptr $clog2(DEPTH) bits, wrap modulo DEPTH. Push writes all five fields at wr_ptr; pop advances rd_ptr. Strict in-order.
- Push when count_q==DEPTH and no pop: entry dropped, pointers/count unchanged, overflow_o set and held until reset.
- Push when full with simultaneous pop: accepted, count_q stays DEPTH.
- Pop when empty: impossible (result_valid_o low); result_ready_i ignored.
- Entries with unit_we_i=0 (NOP/seed) are buffered and returned like any other; the core requires a result per accepted instruction.
- Head fields driven from storage at rd_ptr; stable while result_valid_o & !result_ready_i.

## Timing
- Reset: count_q, inflight_q, pointers, overflow_o = 0; result_valid_o = 0, all result_*_o = 0; issue_ready_o = 1 immediately after reset release (combinationally from zeroed state).
- Execution unit latency 1: issue_fire at edge N → unit_valid_i high in cycle N+1.
- Push at edge M → result_valid_o high in cycle M+1 (no combinational bypass). Issue-to-result_valid_o minimum 2 cycles.
- Pop at edge P: next entry (if any) presented in cycle P+1; back-to-back pops sustain one result per cycle.
- Credit returns on pop: a pop at edge P raises issue_ready_o in cycle P+1 if previously saturated.
- Reset mid-operation: FIFO contents and in-flight credits discarded; outputs return to reset values asynchronously.

## Test plan
- Reset, then single issue with unit result {data=0x0000_1234, rd=5, we=1, id=1} one cycle later, result_ready_i=1 → result_valid_o high exactly one cycle after push with matching fields, then low; issue_ready_o stays 1.
- result_ready_i=0, issue 4 instructions (DEPTH=4) back-to-back → issue_ready_o falls after 4th issue_fire; results ids 0..3 buffered; release ready → ids emitted 0,1,2,3 on consecutive cycles, issue_ready_o rises cycle after first pop.
- Full FIFO, push and pop same cycle (force unit_valid_i) → count stays 4, popped head is oldest, new entry becomes tail, overflow_o stays 0.
- Full FIFO, force unit_valid_i with result_ready_i=0 → overflow_o goes 1 and stays 1; FIFO contents unchanged.
- NOP result {we=0, rd=0, data=0} → returned with result_we_o=0 in order between two FXMADD results.
- Assert rst_ni low with 3 entries buffered and 1 in flight → result_valid_o=0 and issue_ready_o=1 after release; stale entries never appear.
